// File: rtl/fb_slot_scheduler.sv
// Slot controller for the DDR4 frame buffer: hands out free 4 KiB slots, queues written
// slots (with priority nack re-reads) for readout and returns acked slots to the free pool.
module fb_slot_scheduler #(
    parameter int NSLOT     = 256,
    parameter int SLOT_BITS = 12
) (
    input  logic        aclk,
    input  logic        reset_i,
    output logic [7:0]  m_slot_tdata,
    output logic        m_slot_tvalid,
    input  logic        m_slot_tready,
    input  logic [7:0]  s_done_tdata,
    input  logic        s_done_tvalid,
    output logic        s_done_tready,
    input  logic [31:0] s_nack_tdata,
    input  logic        s_nack_tvalid,
    output logic        s_nack_tready,
    output logic [31:0] m_event_tdata,
    output logic        m_event_tvalid,
    input  logic        m_event_tready,
    input  logic [15:0] s_ack_tdata,
    input  logic        s_ack_tvalid,
    output logic        s_ack_tready,
    output logic        allow_o,
    output logic [8:0]  allow_count_o,
    output logic        err_o
);

    localparam int IDX_W = (NSLOT > 1) ? $clog2(NSLOT) : 1;

    // All streams use valid/ready: a transfer happens on a rising aclk edge where both are high,
    // and a source holds tvalid and tdata stable until that edge.

    typedef enum logic {ST_INIT, ST_RUN} state_t;
    state_t state_q, state_d;

    logic [7:0]       fifo_mem [256];
    logic [7:0]       rd_ptr, wr_ptr;
    logic [8:0]       count;
    logic [NSLOT-1:0] busy;

    logic       run, init_wr, pop, ack_fire, ack_ok, push;
    logic [7:0] ack_slot, push_data;
    logic       ev_free, nack_fire, done_fire;
    logic [7:0] ev_slot;

    assign run      = (state_q == ST_RUN);
    assign init_wr  = (state_q == ST_INIT) && (count != 9'(NSLOT));
    assign pop      = m_slot_tvalid && m_slot_tready;
    assign ack_fire = s_ack_tvalid && s_ack_tready;
    assign ack_slot = s_ack_tdata[7:0];
    // Only a slot currently handed out may return; this keeps the free FIFO from overflowing.
    assign ack_ok   = ack_fire && (s_ack_tdata[11:8] == 4'h0)
                      && ({1'b0, ack_slot} < 9'(NSLOT)) && busy[ack_slot[IDX_W-1:0]];
    assign push      = init_wr || ack_ok;
    assign push_data = init_wr ? wr_ptr : ack_slot;

    assign m_slot_tvalid = run && (count != 9'd0);
    assign m_slot_tdata  = fifo_mem[rd_ptr];
    assign s_ack_tready  = run;
    assign allow_count_o = count;

    assign ev_free       = !m_event_tvalid || m_event_tready;
    assign s_nack_tready = run && ev_free;
    assign s_done_tready = run && ev_free && !s_nack_tvalid;
    assign nack_fire     = s_nack_tvalid && s_nack_tready;
    assign done_fire     = s_done_tvalid && s_done_tready;
    assign ev_slot       = nack_fire ? s_nack_tdata[7:0] : s_done_tdata[7:0];

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_INIT: if (count == 9'(NSLOT)) state_d = ST_RUN;
            ST_RUN:  state_d = ST_RUN;
            default: state_d = ST_INIT;
        endcase
    end

    always_ff @(posedge aclk or posedge reset_i) begin
        if (reset_i) state_q <= ST_INIT;
        else         state_q <= state_d;
    end

    // Slot storage carries no reset: INIT rewrites every entry before it can be read.
    always_ff @(posedge aclk) begin
        if (push) fifo_mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge aclk or posedge reset_i) begin
        if (reset_i) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count   <= '0;
            busy    <= '0;
            allow_o <= 1'b0;
            err_o   <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 8'd1;
            if (pop)  rd_ptr <= rd_ptr + 8'd1;
            case ({push, pop})
                2'b10:   count <= count + 9'd1;
                2'b01:   count <= count - 9'd1;
                default: count <= count;
            endcase
            if (ack_ok) busy[ack_slot[IDX_W-1:0]] <= 1'b0;
            if (pop)    busy[m_slot_tdata[IDX_W-1:0]] <= 1'b1;
            allow_o <= ack_fire && s_ack_tdata[15];
            if (ack_fire && !ack_ok) err_o <= 1'b1;
        end
    end

    always_ff @(posedge aclk or posedge reset_i) begin
        if (reset_i) begin
            m_event_tvalid <= 1'b0;
            m_event_tdata  <= '0;
        end else if (ev_free) begin
            m_event_tvalid <= nack_fire || done_fire;
            if (nack_fire || done_fire) m_event_tdata <= 32'(ev_slot) << SLOT_BITS;
        end
    end

endmodule

// File: tb/tb_fb_slot_scheduler.sv
// Directed bench for fb_slot_scheduler: init, allocate/ack, error acks, readout merge, reset.
module tb_fb_slot_scheduler;

    logic        aclk = 1'b0;
    logic        reset_i = 1'b1;
    logic [7:0]  m_slot_tdata;
    logic        m_slot_tvalid;
    logic        m_slot_tready = 1'b0;
    logic [7:0]  s_done_tdata = '0;
    logic        s_done_tvalid = 1'b0;
    logic        s_done_tready;
    logic [31:0] s_nack_tdata = '0;
    logic        s_nack_tvalid = 1'b0;
    logic        s_nack_tready;
    logic [31:0] m_event_tdata;
    logic        m_event_tvalid;
    logic        m_event_tready = 1'b0;
    logic [15:0] s_ack_tdata = '0;
    logic        s_ack_tvalid = 1'b0;
    logic        s_ack_tready;
    logic        allow_o;
    logic [8:0]  allow_count_o;
    logic        err_o;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 aclk = ~aclk;

    fb_slot_scheduler dut (
        .aclk(aclk), .reset_i(reset_i),
        .m_slot_tdata(m_slot_tdata), .m_slot_tvalid(m_slot_tvalid), .m_slot_tready(m_slot_tready),
        .s_done_tdata(s_done_tdata), .s_done_tvalid(s_done_tvalid), .s_done_tready(s_done_tready),
        .s_nack_tdata(s_nack_tdata), .s_nack_tvalid(s_nack_tvalid), .s_nack_tready(s_nack_tready),
        .m_event_tdata(m_event_tdata), .m_event_tvalid(m_event_tvalid),
        .m_event_tready(m_event_tready),
        .s_ack_tdata(s_ack_tdata), .s_ack_tvalid(s_ack_tvalid), .s_ack_tready(s_ack_tready),
        .allow_o(allow_o), .allow_count_o(allow_count_o), .err_o(err_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance n rising edges and settle 2 ns past the last one.
    task automatic cyc(input int n);
        repeat (n) @(posedge aclk);
        #2;
    endtask

    task automatic do_ack(input logic [15:0] d);
        s_ack_tdata  = d;
        s_ack_tvalid = 1'b1;
        cyc(1);
        s_ack_tvalid = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_count"}, 32'(allow_count_o), 32'd0);
        chk({tag, "_slot_valid"}, 32'(m_slot_tvalid), 32'd0);
        chk({tag, "_ack_ready"}, 32'(s_ack_tready), 32'd0);
        chk({tag, "_done_ready"}, 32'(s_done_tready), 32'd0);
        chk({tag, "_nack_ready"}, 32'(s_nack_tready), 32'd0);
        chk({tag, "_ev_valid"}, 32'(m_event_tvalid), 32'd0);
        chk({tag, "_ev_data"}, m_event_tdata, 32'd0);
        chk({tag, "_allow"}, 32'(allow_o), 32'd0);
        chk({tag, "_err"}, 32'(err_o), 32'd0);
    endtask

    initial begin
        // Reset and INIT timing
        cyc(2);
        chk_reset_vals("rst");
        reset_i = 1'b0;
        cyc(256);
        chk("init256_count", 32'(allow_count_o), 32'd256);
        chk("init256_valid", 32'(m_slot_tvalid), 32'd0);
        cyc(1);
        chk("init257_valid", 32'(m_slot_tvalid), 32'd1);
        chk("init257_count", 32'(allow_count_o), 32'd256);

        // Pop every slot in order
        m_slot_tready = 1'b1;
        for (int i = 0; i < 256; i++) begin
            chk("pop_slot", 32'(m_slot_tdata), 32'(i));
            cyc(1);
        end
        m_slot_tready = 1'b0;
        chk("empty_valid", 32'(m_slot_tvalid), 32'd0);
        chk("empty_count", 32'(allow_count_o), 32'd0);

        // Ack with allow returns slot 5
        chk("ack_ready", 32'(s_ack_tready), 32'd1);
        do_ack(16'h8005);
        chk("ack5_count", 32'(allow_count_o), 32'd1);
        chk("ack5_allow", 32'(allow_o), 32'd1);
        chk("ack5_valid", 32'(m_slot_tvalid), 32'd1);
        cyc(1);
        chk("ack5_allow_off", 32'(allow_o), 32'd0);
        chk("ack5_slot", 32'(m_slot_tdata), 32'd5);
        m_slot_tready = 1'b1;
        cyc(1);
        m_slot_tready = 1'b0;
        chk("pop5_count", 32'(allow_count_o), 32'd0);

        // Simultaneous pop and ack keep the count steady
        do_ack(16'h000a);
        chk("ack10_count", 32'(allow_count_o), 32'd1);
        m_slot_tready = 1'b1;
        s_ack_tvalid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            s_ack_tdata = {8'h00, 8'(20 + i)};
            chk("pa_slot", 32'(m_slot_tdata), (i == 0) ? 32'd10 : 32'(19 + i));
            chk("pa_count", 32'(allow_count_o), 32'd1);
            cyc(1);
        end
        s_ack_tvalid = 1'b0;
        m_slot_tready = 1'b0;
        chk("pa_end_count", 32'(allow_count_o), 32'd1);
        chk("pa_end_slot", 32'(m_slot_tdata), 32'd29);
        chk("pa_err", 32'(err_o), 32'd0);
        chk("pa_allow", 32'(allow_o), 32'd0);
        m_slot_tready = 1'b1;
        cyc(1);
        m_slot_tready = 1'b0;
        chk("pa_drain_count", 32'(allow_count_o), 32'd0);

        // Bad acks: slot 7 returned twice, then slot 5 with upper bits set
        do_ack(16'h0007);
        chk("ack7_count", 32'(allow_count_o), 32'd1);
        chk("ack7_err", 32'(err_o), 32'd0);
        chk("ack7_allow", 32'(allow_o), 32'd0);
        do_ack(16'h0007);
        chk("dup7_err", 32'(err_o), 32'd1);
        chk("dup7_count", 32'(allow_count_o), 32'd1);
        do_ack(16'h0105);
        chk("hi5_count", 32'(allow_count_o), 32'd1);
        chk("hi5_err", 32'(err_o), 32'd1);
        chk("hi5_slot", 32'(m_slot_tdata), 32'd7);
        m_slot_tready = 1'b1;
        cyc(1);
        m_slot_tready = 1'b0;
        chk("bad_nopush_valid", 32'(m_slot_tvalid), 32'd0);
        do_ack(16'h0005);
        chk("ok5_count", 32'(allow_count_o), 32'd1);
        chk("ok5_slot", 32'(m_slot_tdata), 32'd5);
        m_slot_tready = 1'b1;
        cyc(1);
        m_slot_tready = 1'b0;

        // Nack has priority over done
        m_event_tready = 1'b1;
        s_done_tdata  = 8'd3;
        s_done_tvalid = 1'b1;
        s_nack_tdata  = 32'h0000_0009;
        s_nack_tvalid = 1'b1;
        #1;
        chk("mrg_done_ready", 32'(s_done_tready), 32'd0);
        chk("mrg_nack_ready", 32'(s_nack_tready), 32'd1);
        cyc(1);
        s_nack_tvalid = 1'b0;
        #1;
        chk("mrg_ev1_valid", 32'(m_event_tvalid), 32'd1);
        chk("mrg_ev1_data", m_event_tdata, 32'h0000_9000);
        chk("mrg_done_ready2", 32'(s_done_tready), 32'd1);
        cyc(1);
        s_done_tvalid = 1'b0;
        chk("mrg_ev2_data", m_event_tdata, 32'h0000_3000);
        chk("mrg_ev2_valid", 32'(m_event_tvalid), 32'd1);
        cyc(1);
        chk("mrg_idle", 32'(m_event_tvalid), 32'd0);

        // Back-pressure holds the event register
        m_event_tready = 1'b0;
        s_done_tdata  = 8'd4;
        s_done_tvalid = 1'b1;
        cyc(1);
        s_done_tdata = 8'd6;
        #1;
        chk("bp_data", m_event_tdata, 32'h0000_4000);
        chk("bp_done_ready", 32'(s_done_tready), 32'd0);
        cyc(2);
        chk("bp_hold_data", m_event_tdata, 32'h0000_4000);
        chk("bp_hold_valid", 32'(m_event_tvalid), 32'd1);
        chk("bp_hold_ready", 32'(s_done_tready), 32'd0);
        m_event_tready = 1'b1;
        #1;
        chk("bp_release_ready", 32'(s_done_tready), 32'd1);
        cyc(1);
        s_done_tvalid = 1'b0;
        chk("bp_next_data", m_event_tdata, 32'h0000_6000);
        cyc(1);
        chk("bp_drained", 32'(m_event_tvalid), 32'd0);

        // Reset mid-stream, then INIT reruns
        m_event_tready = 1'b0;
        s_done_tdata  = 8'd2;
        s_done_tvalid = 1'b1;
        s_ack_tdata   = 16'h8000;
        s_ack_tvalid  = 1'b1;
        cyc(1);
        chk("pre_rst_ev", 32'(m_event_tvalid), 32'd1);
        reset_i = 1'b1;
        #1;
        chk_reset_vals("midrst");
        s_done_tvalid = 1'b0;
        s_ack_tvalid  = 1'b0;
        cyc(2);
        reset_i = 1'b0;
        cyc(256);
        chk("reinit_count", 32'(allow_count_o), 32'd256);
        chk("reinit_valid", 32'(m_slot_tvalid), 32'd0);
        chk("reinit_ack_ready", 32'(s_ack_tready), 32'd0);
        cyc(1);
        chk("reinit_run_valid", 32'(m_slot_tvalid), 32'd1);
        chk("reinit_slot", 32'(m_slot_tdata), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
